// File: rtl/i2c_txn_arbiter.sv
// Round-robin sequencer sharing one I2C master byte engine among N_REQ requesters.
// Each granted request is issued as a start/done handshake, guarded by a watchdog.
module i2c_txn_arbiter #(
    parameter int N_REQ   = 4,
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ-1:0]        req_rw,
    input  logic [N_REQ*DATA_W-1:0] req_wdata,
    output logic [N_REQ-1:0]        req_ready,
    output logic [N_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]       rsp_rdata,
    output logic                    rsp_nack,
    output logic                    rsp_timeout,
    output logic                    m_start,
    output logic [ADDR_W-1:0]       m_address,
    output logic                    m_rw,
    output logic [DATA_W-1:0]       m_wdata,
    output logic                    m_abort,
    input  logic                    m_done,
    input  logic [DATA_W-1:0]       m_rdata,
    input  logic                    m_nack,
    output logic                    busy
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(N_REQ - 1);
    localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t             state_reg;
    logic [IDX_W-1:0]   last_reg;
    logic [N_REQ-1:0]   gnt_mask_reg;
    logic [CNT_W-1:0]   wdog_reg;
    logic [N_REQ-1:0]   req_ready_reg;
    logic [N_REQ-1:0]   rsp_valid_reg;
    logic [DATA_W-1:0]  rsp_rdata_reg;
    logic               rsp_nack_reg;
    logic               rsp_timeout_reg;
    logic               m_start_reg;
    logic [ADDR_W-1:0]  m_address_reg;
    logic               m_rw_reg;
    logic [DATA_W-1:0]  m_wdata_reg;
    logic               m_abort_reg;
    logic               busy_reg;

    logic [ADDR_W-1:0]  addr_arr  [N_REQ];
    logic [DATA_W-1:0]  wdata_arr [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
            assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Search starts just past the last winner, so the previous grantee is considered last.
    logic [IDX_W-1:0] cand;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_found;
    logic [N_REQ-1:0] grant_mask;

    always_comb begin
        cand        = '0;
        grant_idx   = '0;
        grant_found = 1'b0;
        grant_mask  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IDX_W'((int'(last_reg) + k) % N_REQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
        grant_mask[grant_idx] = grant_found;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_reg       <= ST_IDLE;
            last_reg        <= LAST_INIT;
            gnt_mask_reg    <= '0;
            wdog_reg        <= '0;
            req_ready_reg   <= '0;
            rsp_valid_reg   <= '0;
            rsp_rdata_reg   <= '0;
            rsp_nack_reg    <= 1'b0;
            rsp_timeout_reg <= 1'b0;
            m_start_reg     <= 1'b0;
            m_address_reg   <= '0;
            m_rw_reg        <= 1'b0;
            m_wdata_reg     <= '0;
            m_abort_reg     <= 1'b0;
            busy_reg        <= 1'b0;
        end else begin
            req_ready_reg <= '0;
            rsp_valid_reg <= '0;
            m_start_reg   <= 1'b0;
            m_abort_reg   <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (grant_found) begin
                        last_reg      <= grant_idx;
                        gnt_mask_reg  <= grant_mask;
                        m_address_reg <= addr_arr[grant_idx];
                        m_rw_reg      <= req_rw[grant_idx];
                        m_wdata_reg   <= wdata_arr[grant_idx];
                        req_ready_reg <= grant_mask;
                        m_start_reg   <= 1'b1;
                        busy_reg      <= 1'b1;
                        state_reg     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    wdog_reg  <= '0;
                    state_reg <= ST_WAIT;
                end
                ST_WAIT: begin
                    wdog_reg <= wdog_reg + 1'b1;
                    // A completion in the expiry cycle still counts as a normal finish.
                    if (m_done) begin
                        rsp_rdata_reg   <= m_rw_reg ? m_rdata : '0;
                        rsp_nack_reg    <= m_nack;
                        rsp_timeout_reg <= 1'b0;
                        rsp_valid_reg   <= gnt_mask_reg;
                        state_reg       <= ST_RESP;
                    end else if (wdog_reg == WDOG_LAST) begin
                        m_abort_reg     <= 1'b1;
                        rsp_rdata_reg   <= '0;
                        rsp_nack_reg    <= 1'b0;
                        rsp_timeout_reg <= 1'b1;
                        rsp_valid_reg   <= gnt_mask_reg;
                        state_reg       <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    rsp_rdata_reg   <= '0;
                    rsp_nack_reg    <= 1'b0;
                    rsp_timeout_reg <= 1'b0;
                    busy_reg        <= 1'b0;
                    state_reg       <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready   = req_ready_reg;
    assign rsp_valid   = rsp_valid_reg;
    assign rsp_rdata   = rsp_rdata_reg;
    assign rsp_nack    = rsp_nack_reg;
    assign rsp_timeout = rsp_timeout_reg;
    assign m_start     = m_start_reg;
    assign m_address   = m_address_reg;
    assign m_rw        = m_rw_reg;
    assign m_wdata     = m_wdata_reg;
    assign m_abort     = m_abort_reg;
    assign busy        = busy_reg;

endmodule
